// File: rtl/count_event_monitor.sv
// count_event_monitor
//   Watches the free-running stimulus counter. Each valid sample is compared
//   against NUM_MATCH match values. For each match value the block keeps a
//   saturating hit count and the cycle stamp of its first hit. The run ends on
//   the first valid sample with count_in >= END_COUNT. The block then streams
//   one report record per match value over a valid/ready port.
//
// Ports
//   clk           in   clock, all state on posedge
//   reset         in   asynchronous, active-high reset
//   count_valid   in   count_in is valid this cycle
//   count_in      in   counter value under observation (unsigned)
//   match_val     in   packed match values, entry i at [i*WIDTH +: WIDTH]
//   run_done      out  high from end-of-run until reset
//   report_valid  out  report record presented
//   report_ready  in   consumer accepts record
//   report_idx    out  match index of the presented record
//   report_hits   out  hit count for report_idx
//   report_first  out  first-hit cycle stamp, all-ones if never hit
//   report_last   out  record is the final index
//
// States
//   S_RUN    | sampling count_in, cycle counter running
//   S_REPORT | streaming records, statistics frozen
//   S_DONE   | all records accepted, everything frozen until reset

module count_event_monitor #(
    parameter int WIDTH     = 32,
    parameter int NUM_MATCH = 4,
    parameter int HIT_W     = 8,
    parameter int END_COUNT = 99,
    localparam int IDX_W    = (NUM_MATCH > 1) ? $clog2(NUM_MATCH) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       count_valid,
    input  logic [WIDTH-1:0]           count_in,
    input  logic [NUM_MATCH*WIDTH-1:0] match_val,
    output logic                       run_done,
    output logic                       report_valid,
    input  logic                       report_ready,
    output logic [IDX_W-1:0]           report_idx,
    output logic [HIT_W-1:0]           report_hits,
    output logic [WIDTH-1:0]           report_first,
    output logic                       report_last
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_REPORT = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [HIT_W-1:0] HIT_MAX = {HIT_W{1'b1}};
    localparam logic [WIDTH-1:0] END_VAL = WIDTH'(END_COUNT);
    localparam logic [IDX_W-1:0] IDX_END = IDX_W'(NUM_MATCH - 1);

    state_t state_q, state_d;

    logic [WIDTH-1:0] cycle_cnt;
    logic [HIT_W-1:0] hits_q    [NUM_MATCH];
    logic [WIDTH-1:0] first_q   [NUM_MATCH];
    logic [HIT_W-1:0] hits_nxt  [NUM_MATCH];
    logic [WIDTH-1:0] first_nxt [NUM_MATCH];

    logic             end_sample;
    logic             handshake;
    logic [IDX_W-1:0] idx_inc;

    assign end_sample   = count_valid && (count_in >= END_VAL);
    assign handshake    = report_valid && report_ready;
    assign idx_inc      = report_idx + 1'b1;
    assign run_done     = (state_q != S_RUN);
    assign report_valid = (state_q == S_REPORT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_RUN;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:    if (end_sample) state_d = S_REPORT;
            S_REPORT: if (handshake && report_last) state_d = S_DONE;
            S_DONE:   state_d = S_DONE;
            default:  state_d = S_RUN;
        endcase
    end

    // Next-value statistics for the current sample. Record 0 is loaded from
    // these so the end-of-run sample itself is already counted in it.
    always_comb begin
        for (int i = 0; i < NUM_MATCH; i++) begin
            hits_nxt[i]  = hits_q[i];
            first_nxt[i] = first_q[i];
            if (count_valid && (count_in == match_val[i*WIDTH +: WIDTH])) begin
                if (hits_q[i] != HIT_MAX) hits_nxt[i] = hits_q[i] + 1'b1;
                if (hits_q[i] == '0)      first_nxt[i] = cycle_cnt;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt    <= '0;
            for (int i = 0; i < NUM_MATCH; i++) begin
                hits_q[i]  <= '0;
                first_q[i] <= '1;
            end
            report_idx   <= '0;
            report_hits  <= '0;
            report_first <= '0;
            report_last  <= 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    cycle_cnt <= cycle_cnt + 1'b1;
                    for (int i = 0; i < NUM_MATCH; i++) begin
                        hits_q[i]  <= hits_nxt[i];
                        first_q[i] <= first_nxt[i];
                    end
                    if (end_sample) begin
                        report_idx   <= '0;
                        report_hits  <= hits_nxt[0];
                        report_first <= first_nxt[0];
                        report_last  <= (NUM_MATCH == 1);
                    end
                end
                S_REPORT: begin
                    if (handshake && !report_last) begin
                        report_idx   <= idx_inc;
                        report_hits  <= hits_q[idx_inc];
                        report_first <= first_q[idx_inc];
                        report_last  <= (idx_inc == IDX_END);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_count_event_monitor.sv
module tb_count_event_monitor;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int HW = 2;   // small hit width so saturation is reachable
    localparam int EC = 99;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           count_valid;
    logic [W-1:0]   count_in;
    logic [N*W-1:0] match_val;
    logic           run_done;
    logic           report_valid;
    logic           report_ready;
    logic [IW-1:0]  report_idx;
    logic [HW-1:0]  report_hits;
    logic [W-1:0]   report_first;
    logic           report_last;

    count_event_monitor #(
        .WIDTH(W), .NUM_MATCH(N), .HIT_W(HW), .END_COUNT(EC)
    ) dut (
        .clk(clk), .reset(reset), .count_valid(count_valid), .count_in(count_in),
        .match_val(match_val), .run_done(run_done), .report_valid(report_valid),
        .report_ready(report_ready), .report_idx(report_idx), .report_hits(report_hits),
        .report_first(report_first), .report_last(report_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        logic [31:0] c;
    } samp_t;

    samp_t       sq[$];
    int unsigned mv[N];
    int unsigned exp_hits[N];
    logic [31:0] exp_first[N];
    int          end_step;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: hits = number of matching valid samples up to and including
    // the end sample, capped at 2^HW-1; first = index of first matching sample.
    task automatic compute_model();
        int cnt[N];
        end_step = -1;
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0;
            exp_first[i] = 32'hFFFF_FFFF;
        end
        for (int k = 0; k < sq.size(); k++) begin
            if (sq[k].v) begin
                for (int i = 0; i < N; i++) begin
                    if (sq[k].c == mv[i]) begin
                        if (cnt[i] == 0) exp_first[i] = k;
                        cnt[i]++;
                    end
                end
                if (sq[k].c >= EC) begin
                    end_step = k;
                    break;
                end
            end
        end
        for (int i = 0; i < N; i++)
            exp_hits[i] = (cnt[i] > (2**HW - 1)) ? (2**HW - 1) : cnt[i];
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        count_valid  = 1'b0;
        count_in     = '0;
        report_ready = 1'b0;
        for (int i = 0; i < N; i++) match_val[i*W +: W] = mv[i];
        #1;
        check("rst_run_done", run_done, 0);
        check("rst_valid", report_valid, 0);
        check("rst_first", report_first, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // mode 0: ready high; 1: random ready; 2: ready low 5 cycles at record 1
    task automatic run_case(input string name, input int mode, input int abort_at);
        int idx;
        int cyc;
        int low_left;
        logic r;
        compute_model();
        do_reset();
        for (int k = 0; k < sq.size(); k++) begin
            count_valid = sq[k].v;
            count_in    = sq[k].c;
            @(posedge clk);
            @(negedge clk);
            check({name, "_run_done"}, run_done, (k == end_step) ? 1 : 0);
            if (k == end_step) break;
        end
        check({name, "_valid_at_end"}, report_valid, 1);
        idx = 0;
        cyc = 0;
        low_left = 5;
        while (idx < N && cyc < 300) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = 1'($urandom_range(0, 1));
                default: begin
                    r = !(idx == 1 && low_left > 0);
                    if (!r) low_left--;
                end
            endcase
            report_ready = r;
            count_valid  = 1'($urandom_range(0, 1));
            count_in     = $urandom_range(0, 200);
            if (idx == abort_at) begin
                #2 reset = 1'b1;
                #1;
                check({name, "_abort_run_done"}, run_done, 0);
                check({name, "_abort_valid"}, report_valid, 0);
                check({name, "_abort_idx"}, report_idx, 0);
                check({name, "_abort_hits"}, report_hits, 0);
                check({name, "_abort_last"}, report_last, 0);
                return;
            end
            #1;
            check({name, "_rec_valid"}, report_valid, 1);
            check({name, "_rec_idx"}, report_idx, idx);
            check({name, "_rec_hits"}, report_hits, exp_hits[idx]);
            check({name, "_rec_first"}, report_first, exp_first[idx]);
            check({name, "_rec_last"}, report_last, (idx == N - 1) ? 1 : 0);
            @(posedge clk);
            if (r) idx++;
            @(negedge clk);
            cyc++;
        end
        check({name, "_records_done"}, idx, N);
        for (int j = 0; j < 3; j++) begin
            report_ready = 1'($urandom_range(0, 1));
            count_valid  = 1'b1;
            count_in     = $urandom_range(0, 200);
            #1;
            check({name, "_done_valid"}, report_valid, 0);
            check({name, "_done_run_done"}, run_done, 1);
            @(negedge clk);
        end
    endtask

    task automatic ramp(input int last);
        sq.delete();
        for (int k = 0; k <= last; k++) sq.push_back('{1'b1, 32'(k)});
    endtask

    initial begin
        reset = 1'b1;
        count_valid = 1'b0;
        count_in = '0;
        report_ready = 1'b0;
        match_val = '0;

        // T1: basic ramp
        mv = '{30, 50, 300, 500};
        ramp(120);
        run_case("t1", 0, -1);

        // T2: saturation with first stamp 0
        mv = '{7, 1000, 2000, 3000};
        sq.delete();
        for (int k = 0; k < 10; k++) sq.push_back('{1'b1, 32'd7});
        sq.push_back('{1'b1, 32'd99});
        run_case("t2", 0, -1);

        // T3: duplicate match values
        mv = '{30, 30, 30, 30};
        ramp(120);
        run_case("t3", 0, -1);

        // T4: backpressure at record 1
        mv = '{30, 50, 300, 500};
        ramp(120);
        run_case("t4", 2, -1);

        // T5: reset during report, then a clean rerun
        run_case("t5a", 0, 2);
        run_case("t5b", 0, -1);

        // T6: invalid samples on the match and around the end value
        ramp(120);
        sq[30].v = 1'b0;
        sq[99].v = 1'b0;
        sq[100].v = 1'b0;
        run_case("t6", 0, -1);

        // Randomized runs
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++) mv[i] = $urandom_range(0, 45);
            if (r % 2 == 0) mv[1] = mv[0];
            sq.delete();
            for (int k = 0; k < int'($urandom_range(40, 120)); k++) begin
                samp_t s;
                s.v = ($urandom_range(0, 3) != 0);
                s.c = $urandom_range(0, 45);
                if ($urandom_range(0, 9) == 0) s.c = 98;
                if (!s.v && $urandom_range(0, 4) == 0) s.c = 200;
                sq.push_back(s);
            end
            sq.push_back('{1'b1, 32'(99 + $urandom_range(0, 5))});
            run_case("rnd", 1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
